// File: rtl/macguffin_round_ctrl.sv
// MacGuffin round sequencer: owns the 64-bit state, drives the shared S-box layer
// once per cycle and steps through the round keys for encrypt or decrypt.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | applying one round per cycle, busy high
// DONE  | result held on out_block until consumed
module macguffin_round_ctrl #(
    parameter int ROUNDS = 32,
    parameter int WORD   = 16,
    localparam int KW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [4*WORD-1:0] in_block,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*WORD-1:0] out_block,
    output logic [KW-1:0]     key_idx,
    input  logic [3*WORD-1:0] round_key,
    output logic [3*WORD-1:0] sbox_in,
    input  logic [WORD-1:0]   sbox_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [KW-1:0] LAST = KW'(ROUNDS - 1);

    state_t          state, state_nx;
    logic [WORD-1:0] r0, r1, r2, r3;
    logic [WORD-1:0] r0_nx, r1_nx, r2_nx, r3_nx;
    logic [KW-1:0]   rnd, rnd_nx;
    logic            mode_q, mode_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            r0     <= '0;
            r1     <= '0;
            r2     <= '0;
            r3     <= '0;
            rnd    <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nx;
            r0     <= r0_nx;
            r1     <= r1_nx;
            r2     <= r2_nx;
            r3     <= r3_nx;
            rnd    <= rnd_nx;
            mode_q <= mode_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        r0_nx     = r0;
        r1_nx     = r1;
        r2_nx     = r2;
        r3_nx     = r3;
        rnd_nx    = rnd;
        mode_nx   = mode_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        key_idx   = '0;
        sbox_in   = '0;
        out_block = {r0, r1, r2, r3};

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    {r0_nx, r1_nx, r2_nx, r3_nx} = in_block;
                    mode_nx  = mode;
                    rnd_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Decrypt walks the key schedule backwards and rotates the words the other way.
                if (mode_q) begin
                    key_idx = LAST - rnd;
                    sbox_in = {r0, r1, r2} ^ round_key;
                    {r0_nx, r1_nx, r2_nx, r3_nx} = {r3 ^ sbox_out, r0, r1, r2};
                end else begin
                    key_idx = rnd;
                    sbox_in = {r1, r2, r3} ^ round_key;
                    {r0_nx, r1_nx, r2_nx, r3_nx} = {r1, r2, r3, r0 ^ sbox_out};
                end
                rnd_nx = rnd + KW'(1);
                if (rnd == LAST)
                    state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_macguffin_round_ctrl.sv
// Bench for macguffin_round_ctrl: table of blocks checked against a cipher model,
// plus backpressure, input-toggle, mid-run reset and single-round corner cases.
module tb_macguffin_round_ctrl;

    localparam int ROUNDS = 32;
    localparam int WORD   = 16;
    localparam int KW     = $clog2(ROUNDS);
    localparam logic [63:0] PT = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [63:0] in_block, out_block;
    logic [KW-1:0] key_idx;
    logic [47:0] round_key, sbox_in;
    logic [15:0] sbox_out;

    logic        in_valid1, in_ready1, mode1, out_valid1, out_ready1, busy1;
    logic [63:0] in_block1, out_block1;
    logic [0:0]  key_idx1;
    logic [47:0] sbox_in1;

    logic [47:0] keys [ROUNDS];
    logic [1:0]  sbox_tab [8][64];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        m;
        logic [63:0] blk;
        logic [63:0] exp;
        logic        toggle;
    } vec_t;
    localparam int NV = 8;
    vec_t vec [NV];

    always #5 clk = ~clk;

    macguffin_round_ctrl #(.ROUNDS(ROUNDS), .WORD(WORD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .key_idx(key_idx), .round_key(round_key),
        .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy)
    );

    macguffin_round_ctrl #(.ROUNDS(1), .WORD(WORD)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .mode(mode1),
        .in_block(in_block1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_block(out_block1), .key_idx(key_idx1), .round_key(48'h0),
        .sbox_in(sbox_in1), .sbox_out(16'h00FF), .busy(busy1)
    );

    function automatic logic [15:0] sbox_f(input logic [47:0] x);
        logic [15:0] f;
        for (int j = 0; j < 8; j++)
            f[2*j +: 2] = sbox_tab[j][x[6*j +: 6]];
        return f;
    endfunction

    always_comb round_key = keys[key_idx];
    always_comb sbox_out  = sbox_f(sbox_in);

    // Cipher reference: four-word array, one Feistel-style step per round.
    function automatic logic [63:0] model(input logic m, input logic [63:0] blk);
        logic [15:0] w [4];
        logic [15:0] f, t;
        logic [47:0] k;
        for (int j = 0; j < 4; j++) w[j] = blk[63 - 16*j -: 16];
        for (int i = 0; i < ROUNDS; i++) begin
            k = m ? keys[ROUNDS-1-i] : keys[i];
            if (!m) begin
                f = sbox_f({w[1], w[2], w[3]} ^ k);
                t = w[0] ^ f;
                w[0] = w[1]; w[1] = w[2]; w[2] = w[3]; w[3] = t;
            end else begin
                f = sbox_f({w[0], w[1], w[2]} ^ k);
                t = w[3] ^ f;
                w[3] = w[2]; w[2] = w[1]; w[1] = w[0]; w[0] = t;
            end
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic accept(input logic m, input logic [63:0] b);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1; mode = m; in_block = b;
        @(posedge clk); #1;
        in_valid = 1'b0; mode = $urandom; in_block = {$urandom, $urandom};
    endtask

    // Runs the RUN phase: ends one step past the last round edge, where DONE is expected.
    task automatic rounds(input logic m, input logic toggle);
        int kerr = 0, busy_cnt = 0, rdy_err = 0;
        for (int k = 0; k < ROUNDS; k++) begin
            if (key_idx !== KW'(m ? ROUNDS-1-k : k)) kerr++;
            if (busy === 1'b1) busy_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) rdy_err++;
            if (toggle) begin
                in_valid = $urandom; mode = $urandom; in_block = {$urandom, $urandom};
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("key_idx_seq_errors", 64'(kerr), 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'(ROUNDS));
        check("run_handshake_errors", 64'(rdy_err), 64'd0);
        check("out_valid_latency", 64'(out_valid), 64'd1);
        check("busy_in_done", 64'(busy), 64'd0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_drain", 64'(out_valid), 64'd0);
        check("in_ready_after_drain", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] b1, b2, got;
        rst = 1'b1;
        in_valid = 1'b0; mode = 1'b0; in_block = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; mode1 = 1'b0; in_block1 = '0; out_ready1 = 1'b0;
        for (int i = 0; i < ROUNDS; i++) keys[i] = {16'($urandom), $urandom};
        for (int j = 0; j < 8; j++)
            for (int v = 0; v < 64; v++) sbox_tab[j][v] = 2'($urandom);

        vec[0] = '{1'b0, PT, model(1'b0, PT), 1'b0};
        vec[1] = '{1'b1, model(1'b0, PT), PT, 1'b0};
        for (int i = 2; i < NV; i++) begin
            vec[i].m      = 1'($urandom);
            vec[i].blk    = {$urandom, $urandom};
            vec[i].exp    = model(vec[i].m, vec[i].blk);
            vec[i].toggle = (i % 2 == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_block", out_block, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_key_idx", 64'(key_idx), 64'd0);
        check("reset_sbox_in", 64'(sbox_in), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            accept(vec[i].m, vec[i].blk);
            rounds(vec[i].m, vec[i].toggle);
            check($sformatf("vec%0d_out_block", i), out_block, vec[i].exp);
            drain();
        end

        // Backpressure: result held, a competing block waits until after the handshake.
        b1 = {$urandom, $urandom};
        b2 = ~b1;
        accept(1'b0, b1);
        rounds(1'b0, 1'b0);
        got = out_block;
        check("hold_result", got, model(1'b0, b1));
        in_valid = 1'b1; mode = 1'b0; in_block = b2;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_block", out_block, got);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("no_accept_on_handshake_busy", 64'(busy), 64'd0);
        check("idle_after_handshake_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("accept_after_handshake_busy", 64'(busy), 64'd1);
        rounds(1'b0, 1'b0);
        check("second_block_result", out_block, model(1'b0, b2));
        drain();

        // Abort at round 10; the next block must not see any leftover state.
        accept(1'b1, {$urandom, $urandom});
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_block", out_block, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sbox_in", 64'(sbox_in), 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("abort_stays_idle", 64'(busy), 64'd0);
        b1 = {$urandom, $urandom};
        accept(1'b0, b1);
        rounds(1'b0, 1'b0);
        check("post_abort_result", out_block, model(1'b0, b1));
        drain();

        // Single-round instance with constant S-box output 16'h00FF and zero keys.
        in_valid1 = 1'b1; mode1 = 1'b0; in_block1 = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check("r1_enc_busy", 64'(busy1), 64'd1);
        check("r1_enc_key_idx", 64'(key_idx1), 64'd0);
        @(posedge clk); #1;
        check("r1_enc_out_valid", 64'(out_valid1), 64'd1);
        check("r1_enc_out_block", out_block1, 64'h2222_3333_4444_11EE);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; mode1 = 1'b1; in_block1 = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check("r1_dec_key_idx", 64'(key_idx1), 64'd0);
        @(posedge clk); #1;
        check("r1_dec_out_block", out_block1, 64'h44BB_1111_2222_3333);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("r1_idle_after_drain", 64'(in_ready1), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
